// File: rtl/rle_stream_compressor.sv
// Run-length compressor: collapses repeated raw samples into (value, count) words
// and queues them in a small FIFO in front of the memory writer.
module rle_stream_compressor #(
    parameter int DATA_BYTES   = 6,
    parameter int RUN_W        = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [8*DATA_BYTES-1:0]       data_in,
    input  logic                          flush,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic [8*DATA_BYTES-1:0]       mem_data,
    output logic [RUN_W-1:0]              mem_count,
    output logic                          busy,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int IW     = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   cur_val, cur_val_nxt;
    logic [RUN_W-1:0]    run_cnt, run_cnt_nxt;
    logic                flush_pending, flush_pending_nxt;
    logic [IW-1:0]       idle_cnt, idle_cnt_nxt;

    logic                push;
    logic [DATA_W-1:0]   push_data;
    logic [RUN_W-1:0]    push_count;
    logic                same, sat, timeout_hit;

    assign same        = (data_in == cur_val);
    assign sat         = (run_cnt == RUN_MAX);
    assign timeout_hit = (IDLE_TIMEOUT != 0) && (idle_cnt == IW'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cur_val       <= '0;
            run_cnt       <= '0;
            flush_pending <= 1'b0;
            idle_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            cur_val       <= cur_val_nxt;
            run_cnt       <= run_cnt_nxt;
            flush_pending <= flush_pending_nxt;
            idle_cnt      <= idle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        cur_val_nxt       = cur_val;
        run_cnt_nxt       = run_cnt;
        flush_pending_nxt = 1'b0;
        idle_cnt_nxt      = idle_cnt;
        push              = 1'b0;
        push_data         = cur_val;
        push_count        = run_cnt;
        if (flush_pending) begin
            // The deferred run always closes; a sample this cycle starts a fresh run.
            push         = 1'b1;
            idle_cnt_nxt = '0;
            if (valid_in) begin
                state_nxt         = RUN;
                cur_val_nxt       = data_in;
                run_cnt_nxt       = RUN_ONE;
                flush_pending_nxt = flush;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        cur_val_nxt  = data_in;
                        run_cnt_nxt  = RUN_ONE;
                        idle_cnt_nxt = '0;
                        if (flush) begin
                            push       = 1'b1;
                            push_data  = data_in;
                            push_count = RUN_ONE;
                        end else begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    if (valid_in) begin
                        idle_cnt_nxt = '0;
                        if (same && !sat) begin
                            if (flush) begin
                                push       = 1'b1;
                                push_count = run_cnt + 1'b1;
                                state_nxt  = IDLE;
                            end else begin
                                run_cnt_nxt = run_cnt + 1'b1;
                            end
                        end else begin
                            // Only one push per cycle, so a flush here is deferred a cycle.
                            push              = 1'b1;
                            cur_val_nxt       = data_in;
                            run_cnt_nxt       = RUN_ONE;
                            flush_pending_nxt = flush;
                        end
                    end else if (flush || timeout_hit) begin
                        push         = 1'b1;
                        state_nxt    = IDLE;
                        idle_cnt_nxt = '0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    logic [AW:0]        wr_ptr, rd_ptr;
    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [RUN_W-1:0]   fifo_cnt  [FIFO_DEPTH];
    logic               pop, full, accept, drop;

    assign fifo_level = wr_ptr - rd_ptr;
    assign mem_valid  = (fifo_level != '0);
    assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign pop        = mem_valid && mem_ready;
    assign accept     = push && (!full || pop);
    assign drop       = push && !accept;
    assign mem_data   = mem_valid ? fifo_data[rd_ptr[AW-1:0]] : '0;
    assign mem_count  = mem_valid ? fifo_cnt[rd_ptr[AW-1:0]]  : '0;
    assign busy       = (state == RUN) || flush_pending || mem_valid;

    always_ff @(posedge clock) begin
        if (accept) begin
            fifo_data[wr_ptr[AW-1:0]] <= push_data;
            fifo_cnt[wr_ptr[AW-1:0]]  <= push_count;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            end
        end
    end
endmodule
